// File: rtl/sonar_pkg.sv
// Shared state encoding, default timing and sizing helpers for the sonar array controller.
package sonar_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_HOLDOFF
    } state_e;

    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_CNT_W       = 24;
    localparam int DEF_TRIG_CYC    = 120;
    localparam int DEF_RISE_TO_CYC = 12000;
    localparam int DEF_MAX_CYC     = 360000;
    localparam int DEF_HOLDOFF_CYC = 720000;
    localparam int DEF_NEAR_CYC    = 17400;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bits needed to hold a counter running 0 .. n-1.
    function automatic int cnt_bits(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sonar_sync.sv
// NUM_CH-wide two-flop synchroniser for the raw asynchronous echo lines.
module sonar_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/sonar_array_ctrl.sv
// Round-robin ultrasonic ranging controller: trigger one channel, time its echo, report, hold off.
module sonar_array_ctrl
    import sonar_pkg::*;
#(
    parameter  int NUM_CH      = DEF_NUM_CH,
    parameter  int CNT_W       = DEF_CNT_W,
    parameter  int TRIG_CYC    = DEF_TRIG_CYC,
    parameter  int RISE_TO_CYC = DEF_RISE_TO_CYC,
    parameter  int MAX_CYC     = DEF_MAX_CYC,
    parameter  int HOLDOFF_CYC = DEF_HOLDOFF_CYC,
    parameter  int NEAR_CYC    = DEF_NEAR_CYC,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [NUM_CH-1:0] echo,
    output logic [NUM_CH-1:0] trig,
    output logic              busy,
    output logic              result_valid,
    output logic [CH_W-1:0]   result_ch,
    output logic [CNT_W-1:0]  result_cycles,
    output logic              result_timeout,
    output logic [NUM_CH-1:0] near
);

    localparam int TMR_W = cnt_bits(max3(TRIG_CYC, RISE_TO_CYC, HOLDOFF_CYC));

    state_e            state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [NUM_CH-1:0] echo_s, echo_prev_q, echo_prev_d;
    logic              result_valid_q, result_valid_d;
    logic [CH_W-1:0]   result_ch_q, result_ch_d;
    logic [CNT_W-1:0]  result_cycles_q, result_cycles_d;
    logic              result_timeout_q, result_timeout_d;
    logic [NUM_CH-1:0] near_q, near_d;

    logic              sel_found;
    logic [CH_W-1:0]   sel_ch, cand;
    logic              echo_rise;
    logic              done, done_to;
    logic [CNT_W-1:0]  done_cyc;

    sonar_sync #(.WIDTH(NUM_CH)) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (echo),
        .sync_out (echo_s)
    );

    // ch_q holds the last channel pinged; the search starts one past it and wraps.
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = ch_q;
        cand      = ch_q;
        for (int off = NUM_CH; off >= 1; off--) begin
            cand = CH_W'((int'(ch_q) + off) % NUM_CH);
            if (ch_mask[cand]) begin
                sel_found = 1'b1;
                sel_ch    = cand;
            end
        end
    end

    assign echo_rise = echo_s[ch_q] & ~echo_prev_q[ch_q];

    // NOTE: every variable assigned below gets a default first, so no path can infer a latch.
    always_comb begin
        state_d          = state_q;
        tmr_d            = tmr_q;
        cnt_d            = cnt_q;
        ch_d             = ch_q;
        echo_prev_d      = echo_s;
        result_valid_d   = 1'b0;
        result_ch_d      = result_ch_q;
        result_cycles_d  = result_cycles_q;
        result_timeout_d = result_timeout_q;
        near_d           = near_q;
        done             = 1'b0;
        done_to          = 1'b0;
        done_cyc         = '0;

        case (state_q)
            ST_IDLE: begin
                if (enable && sel_found) begin
                    state_d = ST_TRIG;
                    ch_d    = sel_ch;
                    tmr_d   = '0;
                end
            end
            ST_TRIG: begin
                if (tmr_q == TMR_W'(TRIG_CYC - 1)) begin
                    state_d = ST_WAIT_RISE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_WAIT_RISE: begin
                if (echo_rise) begin
                    state_d = ST_MEASURE;
                    cnt_d   = CNT_W'(1);
                end else if (tmr_q == TMR_W'(RISE_TO_CYC - 1)) begin
                    done    = 1'b1;
                    done_to = 1'b1;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_MEASURE: begin
                if (!echo_s[ch_q]) begin
                    done     = 1'b1;
                    done_cyc = cnt_q;
                end else if (cnt_q == CNT_W'(MAX_CYC - 1)) begin
                    // Still high on the cycle the count reaches MAX_CYC: saturate and give up.
                    done     = 1'b1;
                    done_to  = 1'b1;
                    done_cyc = CNT_W'(MAX_CYC);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLDOFF: begin
                if (tmr_q == TMR_W'(HOLDOFF_CYC - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (done) begin
            state_d          = ST_HOLDOFF;
            tmr_d            = '0;
            result_valid_d   = 1'b1;
            result_ch_d      = ch_q;
            result_cycles_d  = done_cyc;
            result_timeout_d = done_to;
            near_d[ch_q]     = !done_to && (done_cyc < CNT_W'(NEAR_CYC));
        end
    end

    // NOTE: the pointer resets to the last channel so that channel 0 is the first one searched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            tmr_q            <= '0;
            cnt_q            <= '0;
            ch_q             <= CH_W'(NUM_CH - 1);
            echo_prev_q      <= '0;
            result_valid_q   <= 1'b0;
            result_ch_q      <= '0;
            result_cycles_q  <= '0;
            result_timeout_q <= 1'b0;
            near_q           <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of every other flop.
            state_q          <= state_d;
            tmr_q            <= tmr_d;
            cnt_q            <= cnt_d;
            ch_q             <= ch_d;
            echo_prev_q      <= echo_prev_d;
            result_valid_q   <= result_valid_d;
            result_ch_q      <= result_ch_d;
            result_cycles_q  <= result_cycles_d;
            result_timeout_q <= result_timeout_d;
            near_q           <= near_d;
        end
    end

    always_comb begin
        trig = '0;
        if (state_q == ST_TRIG) begin
            trig[ch_q] = 1'b1;
        end
    end

    assign busy           = (state_q != ST_IDLE);
    assign result_valid   = result_valid_q;
    assign result_ch      = result_ch_q;
    assign result_cycles  = result_cycles_q;
    assign result_timeout = result_timeout_q;
    assign near           = near_q;

endmodule

// File: tb/tb_sonar_array_ctrl.sv
// Randomised ping/echo stimulus against a transaction-level model of the sonar controller.
module tb_sonar_array_ctrl;

    localparam int NUM_CH      = 4;
    localparam int CNT_W       = 16;
    localparam int TRIG_CYC    = 8;
    localparam int RISE_TO_CYC = 120;
    localparam int MAX_CYC     = 1000;
    localparam int HOLDOFF_CYC = 200;
    localparam int NEAR_CYC    = 600;
    localparam int CH_W        = 2;

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic [NUM_CH-1:0] ch_mask;
    logic [NUM_CH-1:0] echo;
    logic [NUM_CH-1:0] trig;
    logic              busy;
    logic              result_valid;
    logic [CH_W-1:0]   result_ch;
    logic [CNT_W-1:0]  result_cycles;
    logic              result_timeout;
    logic [NUM_CH-1:0] near;

    logic [NUM_CH-1:0] echo_main;
    logic [NUM_CH-1:0] echo_noise;
    logic [NUM_CH-1:0] sel_bit;
    logic              noise_en;

    int                total;
    int                bad;
    int                last_ch_m;
    logic [NUM_CH-1:0] near_m;

    assign echo = echo_main | echo_noise;

    sonar_array_ctrl #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .TRIG_CYC    (TRIG_CYC),
        .RISE_TO_CYC (RISE_TO_CYC),
        .MAX_CYC     (MAX_CYC),
        .HOLDOFF_CYC (HOLDOFF_CYC),
        .NEAR_CYC    (NEAR_CYC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .ch_mask        (ch_mask),
        .echo           (echo),
        .trig           (trig),
        .busy           (busy),
        .result_valid   (result_valid),
        .result_ch      (result_ch),
        .result_cycles  (result_cycles),
        .result_timeout (result_timeout),
        .near           (near)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Random chatter on every channel except the one being pinged.
    initial begin
        echo_noise = '0;
        forever begin
            @(negedge clk);
            echo_noise = noise_en ? (NUM_CH'($urandom) & ~sel_bit) : '0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int next_ch(input logic [NUM_CH-1:0] m, input int last);
        for (int k = 1; k <= NUM_CH; k++) begin
            if (m[(last + k) % NUM_CH]) return (last + k) % NUM_CH;
        end
        return -1;
    endfunction

    // One complete ping; width 0 means the echo never rises.
    task automatic ping(input logic [NUM_CH-1:0] mask, input int dly, input int width, input bit drop_en);
        int ch;
        int n;
        int k;
        bit exp_to;
        int exp_cyc;
        ch_mask = mask;
        ch = next_ch(mask, last_ch_m);
        n = 0;
        while (trig == '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("trig_seen", 32'(trig != '0), 32'd1);
        if (trig == '0) return;
        last_ch_m = ch;
        sel_bit = NUM_CH'(1) << ch;
        check("trig_onehot", 32'(trig), 32'(sel_bit));
        n = 0;
        while (trig != '0 && n < 4 * TRIG_CYC) begin
            n++;
            @(negedge clk);
        end
        check("trig_len", 32'(n), 32'(TRIG_CYC));
        ch_mask = NUM_CH'($urandom);
        if (drop_en) enable = 1'b0;
        if (width == 0) begin
            exp_to = 1'b1;
            exp_cyc = 0;
        end else if (width >= MAX_CYC) begin
            exp_to = 1'b1;
            exp_cyc = MAX_CYC;
        end else begin
            exp_to = 1'b0;
            exp_cyc = width;
        end
        near_m[ch] = !exp_to && (exp_cyc < NEAR_CYC);
        fork
            begin
                if (width > 0) begin
                    repeat (dly) @(negedge clk);
                    echo_main[ch] = 1'b1;
                    repeat (width) @(negedge clk);
                    echo_main[ch] = 1'b0;
                end
            end
            begin
                k = 0;
                while (!result_valid && k < RISE_TO_CYC + MAX_CYC + 50) begin
                    @(negedge clk);
                    k++;
                end
                check("strobe_seen", 32'(result_valid), 32'd1);
                if (result_valid) begin
                    if (width == 0) check("rise_to_latency", 32'(k), 32'(RISE_TO_CYC));
                    check("result_ch", 32'(result_ch), 32'(ch));
                    check("result_cycles", 32'(result_cycles), 32'(exp_cyc));
                    check("result_timeout", 32'(result_timeout), 32'(exp_to));
                    check("near", 32'(near), 32'(near_m));
                    check("busy_holdoff", 32'(busy), 32'd1);
                    @(negedge clk);
                    check("strobe_one_cycle", 32'(result_valid), 32'd0);
                    k = 1;
                    while (busy && k < HOLDOFF_CYC + 20) begin
                        @(negedge clk);
                        k++;
                    end
                    check("holdoff_len", 32'(k), 32'(HOLDOFF_CYC));
                    check("result_hold", 32'(result_cycles), 32'(exp_cyc));
                end
            end
        join
    endtask

    task automatic idle_watch(input string tag, input int cycles);
        int viol;
        viol = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (busy || trig != '0) viol++;
        end
        check(tag, 32'(viol), 32'd0);
    endtask

    initial begin
        int ch;
        int n;
        total     = 0;
        bad       = 0;
        last_ch_m = NUM_CH - 1;
        near_m    = '0;
        rst_n     = 1'b1;
        enable    = 1'b0;
        ch_mask   = '0;
        echo_main = '0;
        sel_bit   = '0;
        noise_en  = 1'b0;
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_trig", 32'(trig), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_cycles", 32'(result_cycles), 32'd0);
        check("rst_near", 32'(near), 32'd0);
        rst_n  = 1'b1;
        enable = 1'b1;

        // Basic alternating mask, then rise timeout clearing a set near flag.
        ping(4'b0101, 50, 500, 1'b0);
        ping(4'b0101, 10, 700, 1'b0);
        ping(4'b0101, 0, 0, 1'b0);
        // Width boundaries around MAX_CYC and NEAR_CYC.
        ping(4'b1111, 5, MAX_CYC + 40, 1'b0);
        ping(4'b1111, 5, MAX_CYC - 1, 1'b0);
        ping(4'b1111, 30, NEAR_CYC - 1, 1'b0);
        ping(4'b1111, 30, NEAR_CYC, 1'b0);

        noise_en = 1'b1;
        ping(4'b1000, 20, 250, 1'b0);

        for (int i = 0; i < 16; i++) begin
            logic [NUM_CH-1:0] m;
            int w;
            m = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
            if ($urandom_range(0, 7) == 0) w = 0;
            else w = int'($urandom_range(1, MAX_CYC + 20));
            ping(m, int'($urandom_range(1, 60)), w, 1'b0);
        end

        // Enable dropped mid-ping: that ping completes, nothing follows.
        ping(4'b1111, 15, 400, 1'b1);
        idle_watch("idle_enable0", 2 * HOLDOFF_CYC);
        ch_mask = '0;
        enable  = 1'b1;
        idle_watch("idle_mask0", 2 * HOLDOFF_CYC);

        // Reset during MEASURE.
        ch_mask = '1;
        ch = next_ch('1, last_ch_m);
        n = 0;
        while (trig == '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("rst_ping_trig_seen", 32'(trig != '0), 32'd1);
        sel_bit = NUM_CH'(1) << ch;
        repeat (TRIG_CYC + 10) @(negedge clk);
        echo_main[ch] = 1'b1;
        repeat (30) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_trig", 32'(trig), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(result_valid), 32'd0);
        check("mid_rst_ch", 32'(result_ch), 32'd0);
        check("mid_rst_cycles", 32'(result_cycles), 32'd0);
        check("mid_rst_timeout", 32'(result_timeout), 32'd0);
        check("mid_rst_near", 32'(near), 32'd0);
        echo_main = '0;
        @(negedge clk);
        rst_n     = 1'b1;
        last_ch_m = NUM_CH - 1;
        near_m    = '0;
        ping('1, 20, 300, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
